// File: rtl/rram_ctrl_pkg.sv
// rram_ctrl_pkg: shared op/state encodings and default phase timing for the RRAM access controller
package rram_ctrl_pkg;
   typedef enum logic [1:0] {OP_READ, OP_SET, OP_RESET, OP_ILLEGAL} op_e;
   typedef enum logic [2:0] {IDLE, SETUP, SENSE, PULSE, HOLD, RESP} state_e;
   localparam int DEF_NWORD   = 6;
   localparam int DEF_T_SETUP = 2;
   localparam int DEF_T_PULSE = 4;
   localparam int DEF_T_SENSE = 3;
   localparam int DEF_T_HOLD  = 1;
   localparam int DEF_CNT_W   = 8;
endpackage

// File: rtl/rram_access_ctrl_timer.sv
// rram_phase_timer: loadable down-counter shared by all controller phases
module rram_phase_timer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   output logic [CNT_W-1:0] o_value,
   output logic             o_done
);
   logic [CNT_W-1:0] r_cnt;
   always_ff @(posedge clk) begin
      if (rst) r_cnt <= '0;
      else if (i_load) r_cnt <= i_value;
      else if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
   end
   assign o_value = r_cnt;
   assign o_done  = (r_cnt == '0);
endmodule

// File: rtl/rram_access_ctrl.sv
// rram_access_ctrl: sequences program/read accesses to one RRAM array and its column decoder
module rram_access_ctrl
   import rram_ctrl_pkg::*;
#(
   parameter int NWORD   = DEF_NWORD,
   parameter int T_SETUP = DEF_T_SETUP,
   parameter int T_PULSE = DEF_T_PULSE,
   parameter int T_SENSE = DEF_T_SENSE,
   parameter int T_HOLD  = DEF_T_HOLD,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [NWORD-1:0] req_row,
   input  logic [NWORD-1:0] req_col,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [7:0]       rsp_data,
   output logic             rsp_err,
   output logic [NWORD-1:0] wl_adr,
   output logic             wl_en,
   output logic [NWORD-1:0] dec_adr,
   output logic             dec_read,
   output logic             dec_csl,
   output logic             prog_set,
   output logic             prog_reset,
   output logic             sense_en,
   input  logic [7:0]       sense_data
);
   localparam int T_MAX = (1 << CNT_W) - 1;
   if (T_SETUP < 1 || T_SETUP > T_MAX || T_PULSE < 1 || T_PULSE > T_MAX ||
       T_SENSE < 1 || T_SENSE > T_MAX || T_HOLD < 1 || T_HOLD > T_MAX) begin : g_bad_timing
      $error("rram_access_ctrl: every phase time must lie in 1..2**CNT_W-1");
   end
   localparam logic [CNT_W-1:0] L_SETUP = CNT_W'(T_SETUP - 1);
   localparam logic [CNT_W-1:0] L_PULSE = CNT_W'(T_PULSE - 1);
   localparam logic [CNT_W-1:0] L_SENSE = CNT_W'(T_SENSE - 1);
   localparam logic [CNT_W-1:0] L_HOLD  = CNT_W'(T_HOLD - 1);
   state_e           r_state;
   op_e              r_op;
   logic             r_req_ready, r_rsp_valid, r_rsp_err;
   logic [7:0]       r_rsp_data;
   logic [NWORD-1:0] r_wl_adr, r_dec_adr;
   logic             r_wl_en, r_dec_read, r_dec_csl, r_prog_set, r_prog_reset, r_sense_en;
   logic             w_accept, w_load, w_done;
   logic [CNT_W-1:0] w_load_val, w_value;
   op_e              w_op;
   assign w_op       = op_e'(req_op);
   assign w_accept   = (r_state == IDLE) && req_valid && (w_op != OP_ILLEGAL);
   assign w_load     = w_accept || (w_done && (r_state inside {SETUP, SENSE, PULSE}));
   assign w_load_val = w_accept ? L_SETUP :
                       (r_state == SETUP) ? (r_dec_read ? L_SENSE : L_PULSE) : L_HOLD;
   rram_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load),
      .i_value (w_load_val),
      .o_value (w_value),
      .o_done  (w_done)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op         <= OP_READ;
         r_req_ready  <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_err    <= 1'b0;
         r_wl_adr     <= '0;
         r_wl_en      <= 1'b0;
         r_dec_adr    <= '0;
         r_dec_read   <= 1'b0;
         r_dec_csl    <= 1'b0;
         r_prog_set   <= 1'b0;
         r_prog_reset <= 1'b0;
         r_sense_en   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (req_valid) begin
               r_op        <= w_op;
               r_req_ready <= 1'b0;
               r_rsp_data  <= '0;
               r_rsp_err   <= (w_op == OP_ILLEGAL);
               r_rsp_valid <= (w_op == OP_ILLEGAL);
               r_state     <= (w_op == OP_ILLEGAL) ? RESP : SETUP;
               r_wl_en     <= (w_op != OP_ILLEGAL);
               r_wl_adr    <= (w_op != OP_ILLEGAL) ? req_row : '0;
               r_dec_adr   <= (w_op != OP_ILLEGAL) ? req_col : '0;
               r_dec_read  <= (w_op == OP_READ);
            end
            SETUP: if (w_done) begin
               r_dec_csl    <= 1'b1;
               r_sense_en   <= r_dec_read;
               r_prog_set   <= (r_op == OP_SET);
               r_prog_reset <= (r_op == OP_RESET);
               r_state      <= r_dec_read ? SENSE : PULSE;
            end
            SENSE: begin
               // the sense window closes when the timer has run out
               if (w_value == '0) r_rsp_data <= sense_data;
               if (w_done) begin
                  r_dec_csl  <= 1'b0;
                  r_sense_en <= 1'b0;
                  r_state    <= HOLD;
               end
            end
            PULSE: if (w_done) begin
               r_dec_csl    <= 1'b0;
               r_prog_set   <= 1'b0;
               r_prog_reset <= 1'b0;
               r_state      <= HOLD;
            end
            HOLD: if (w_done) begin
               r_wl_en     <= 1'b0;
               r_wl_adr    <= '0;
               r_dec_adr   <= '0;
               r_dec_read  <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_rsp_data  <= '0;
               r_rsp_err   <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
   assign req_ready  = r_req_ready;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_err    = r_rsp_err;
   assign wl_adr     = r_wl_adr;
   assign wl_en      = r_wl_en;
   assign dec_adr    = r_dec_adr;
   assign dec_read   = r_dec_read;
   assign dec_csl    = r_dec_csl;
   assign prog_set   = r_prog_set;
   assign prog_reset = r_prog_reset;
   assign sense_en   = r_sense_en;
endmodule

// File: tb/tb_rram_access_ctrl.sv
// tb_rram_access_ctrl: directed vector bench for the default and a fast-timing controller
module tb_rram_access_ctrl;
   typedef struct packed {
      logic       req_ready;
      logic       rsp_valid;
      logic [7:0] rsp_data;
      logic       rsp_err;
      logic [5:0] wl_adr;
      logic       wl_en;
      logic [5:0] dec_adr;
      logic       dec_read;
      logic       dec_csl;
      logic       prog_set;
      logic       prog_reset;
      logic       sense_en;
   } out_t;
   typedef struct {
      bit         sel;
      logic [1:0] op;
      logic [5:0] row, col;
      logic [7:0] sense;
      int         hold, lat;
      logic [7:0] data;
      logic       err;
      int         csl_first, csl_n, set_n, rst_n, sen_n, wl_n;
      logic       rd;
   } vec_t;
   logic       clk = 1'b0, rst = 1'b1, sel = 1'b0, req_valid = 1'b0, rsp_ready = 1'b0;
   logic [1:0] req_op = '0;
   logic [5:0] req_row = '0, req_col = '0;
   logic [7:0] sense_data = '0;
   out_t       o1, o2, o, p1, p2, z;
   int         n_chk = 0, n_pass = 0, inv_bad = 0;
   vec_t       tv [7];
   always #5 clk = ~clk;
   assign o = sel ? o2 : o1;
   rram_access_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(o1.req_ready),
      .req_op(req_op), .req_row(req_row), .req_col(req_col),
      .rsp_valid(o1.rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o1.rsp_data), .rsp_err(o1.rsp_err),
      .wl_adr(o1.wl_adr), .wl_en(o1.wl_en), .dec_adr(o1.dec_adr), .dec_read(o1.dec_read),
      .dec_csl(o1.dec_csl), .prog_set(o1.prog_set), .prog_reset(o1.prog_reset),
      .sense_en(o1.sense_en), .sense_data(sense_data)
   );
   rram_access_ctrl #(.T_SETUP(1), .T_PULSE(1), .T_HOLD(1)) dut_fast (
      .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(o2.req_ready),
      .req_op(req_op), .req_row(req_row), .req_col(req_col),
      .rsp_valid(o2.rsp_valid), .rsp_ready(rsp_ready), .rsp_data(o2.rsp_data), .rsp_err(o2.rsp_err),
      .wl_adr(o2.wl_adr), .wl_en(o2.wl_en), .dec_adr(o2.dec_adr), .dec_read(o2.dec_read),
      .dec_csl(o2.dec_csl), .prog_set(o2.prog_set), .prog_reset(o2.prog_reset),
      .sense_en(o2.sense_en), .sense_data(sense_data)
   );
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask
   function automatic int inv(input out_t c, input out_t p);
      return int'((c.prog_set & c.prog_reset) | (c.sense_en & ~c.dec_read) | (c.dec_csl & ~c.wl_en) |
                  (c.dec_csl & p.dec_csl & ((c.dec_read != p.dec_read) | (c.dec_adr != p.dec_adr))) |
                  ((c.req_ready | c.rsp_valid) &
                   (c.wl_en | c.dec_csl | c.prog_set | c.prog_reset | c.sense_en)));
   endfunction
   always @(negedge clk) begin
      if (!rst) inv_bad += inv(o1, p1) + inv(o2, p2);
      p1 = o1;
      p2 = o2;
   end
   task automatic txn(input vec_t v, input int id);
      int w = 0, c = 0, first = -1, csl_first = -1, csl_n = 0, set_n = 0, rst_n = 0, sen_n = 0;
      int wl_n = 0, adr_bad = 0, unstable = 0, busy_rdy = 0;
      logic [7:0] d = '0;
      logic e = 1'b0, rd = 1'b0, done = 1'b0;
      if (sel != v.sel) begin
         sel = v.sel;
         @(negedge clk);
      end
      sense_data = v.sense;
      while (!o.req_ready && w < 10) begin
         @(negedge clk);
         w++;
      end
      req_valid = 1'b1;
      req_op = v.op;
      req_row = v.row;
      req_col = v.col;
      while (!done && c < 40) begin
         @(negedge clk);
         c++;
         req_op = 2'b11;
         req_row = ~v.row;
         req_col = ~v.col;
         busy_rdy += int'(o.req_ready);
         if (o.wl_en) begin
            wl_n++;
            if (o.wl_adr != v.row || o.dec_adr != v.col) adr_bad++;
         end
         if (o.dec_csl) begin
            if (csl_first < 0) begin
               csl_first = c;
               rd = o.dec_read;
            end
            csl_n++;
         end
         set_n += int'(o.prog_set);
         rst_n += int'(o.prog_reset);
         sen_n += int'(o.sense_en);
         if (o.rsp_valid) begin
            if (first < 0) begin
               first = c;
               d = o.rsp_data;
               e = o.rsp_err;
            end else if (o.rsp_data != d || o.rsp_err != e) unstable++;
            if (c - first >= v.hold) begin
               rsp_ready = 1'b1;
               req_valid = 1'b0;
               done = 1'b1;
            end
         end
      end
      req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_done", id), int'(done), 1);
      chk($sformatf("v%0d_ready_after", id), int'(o.req_ready), 1);
      chk($sformatf("v%0d_valid_after", id), int'(o.rsp_valid), 0);
      rsp_ready = 1'b0;
      chk($sformatf("v%0d_accept_wait", id), w, 0);
      chk($sformatf("v%0d_latency", id), first, v.lat);
      chk($sformatf("v%0d_data", id), int'(d), int'(v.data));
      chk($sformatf("v%0d_err", id), int'(e), int'(v.err));
      chk($sformatf("v%0d_csl_first", id), csl_first, v.csl_first);
      chk($sformatf("v%0d_csl_cycles", id), csl_n, v.csl_n);
      chk($sformatf("v%0d_set_cycles", id), set_n, v.set_n);
      chk($sformatf("v%0d_reset_cycles", id), rst_n, v.rst_n);
      chk($sformatf("v%0d_sense_cycles", id), sen_n, v.sen_n);
      chk($sformatf("v%0d_wl_cycles", id), wl_n, v.wl_n);
      chk($sformatf("v%0d_dec_read", id), int'(rd), int'(v.rd));
      chk($sformatf("v%0d_adr_bad", id), adr_bad, 0);
      chk($sformatf("v%0d_rsp_unstable", id), unstable, 0);
      chk($sformatf("v%0d_busy_ready", id), busy_rdy, 0);
   endtask
   initial begin
      int nv;
      tv[0] = '{1'b0, 2'b00, 6'd5,  6'd3,  8'hA5, 0, 7, 8'hA5, 1'b0,  3, 3, 0, 0, 3, 6, 1'b1};
      tv[1] = '{1'b0, 2'b01, 6'd63, 6'd63, 8'hFF, 0, 8, 8'h00, 1'b0,  3, 4, 4, 0, 0, 7, 1'b0};
      tv[2] = '{1'b0, 2'b11, 6'd9,  6'd9,  8'h11, 0, 1, 8'h00, 1'b1, -1, 0, 0, 0, 0, 0, 1'b0};
      tv[3] = '{1'b0, 2'b10, 6'd0,  6'd0,  8'h3C, 5, 8, 8'h00, 1'b0,  3, 4, 0, 4, 0, 7, 1'b0};
      tv[4] = '{1'b0, 2'b00, 6'd63, 6'd7,  8'h5A, 2, 7, 8'h5A, 1'b0,  3, 3, 0, 0, 3, 6, 1'b1};
      tv[5] = '{1'b1, 2'b01, 6'd1,  6'd2,  8'h00, 0, 4, 8'h00, 1'b0,  2, 1, 1, 0, 0, 3, 1'b0};
      tv[6] = '{1'b1, 2'b00, 6'd62, 6'd5,  8'hC3, 0, 6, 8'hC3, 1'b0,  2, 3, 0, 0, 3, 5, 1'b1};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      z = o1;
      z.req_ready = 1'b0;
      chk("reset_outputs", int'(z != '0), 0);
      chk("reset_ready", int'(o1.req_ready), 1);
      chk("reset_ready_fast", int'(o2.req_ready), 1);
      for (int i = 0; i < 7; i++) txn(tv[i], i);
      sel = 1'b0;
      @(negedge clk);
      req_valid = 1'b1;
      req_op = 2'b01;
      req_row = 6'd10;
      req_col = 6'd20;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("midrst_pulse_active", int'(o.prog_set), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      z = o;
      z.req_ready = 1'b0;
      chk("midrst_outputs", int'(z != '0), 0);
      chk("midrst_ready", int'(o.req_ready), 1);
      nv = 0;
      repeat (3) begin
         @(negedge clk);
         nv += int'(o.rsp_valid);
      end
      chk("midrst_no_rsp", nv, 0);
      txn(tv[0], 7);
      chk("invariants", inv_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
